// File: rtl/noc_flit_packetizer.sv
// Credit-based NoC ingress packetizer: header request + len+1 beats -> head/body/tail flits on one VC.
// Optional in_last cross-check and sticky err_len enabled by NOC_PKT_LEN_CHECK_EN.

module noc_pkt_vc_credit #(
  parameter int DEPTH  = 4,
  parameter int CRED_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inc,
  input  logic              dec,
  output logic [CRED_W-1:0] cnt,
  output logic              avail
);
  localparam logic [CRED_W-1:0] FULL = CRED_W'(DEPTH);

  always_ff @(posedge clk) begin
    if (rst)                            cnt <= FULL;
    else if (inc && !dec && cnt != FULL) cnt <= cnt + 1'b1;
    else if (dec && !inc)               cnt <= cnt - 1'b1;
  end

  assign avail = (cnt != '0);
endmodule

module noc_flit_packetizer #(
  parameter int DATA_W   = 64,
  parameter int X_W      = 4,
  parameter int Y_W      = 4,
  parameter int TYPE_W   = 2,
  parameter int ORDER_W  = 4,
  parameter int LEN_W    = 8,
  parameter int VC_NUM   = 2,
  parameter int VC_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [X_W-1:0]       local_x,
  input  logic [Y_W-1:0]       local_y,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [X_W-1:0]       req_dest_x,
  input  logic [Y_W-1:0]       req_dest_y,
  input  logic [TYPE_W-1:0]    req_type,
  input  logic [ORDER_W-1:0]   req_order,
  input  logic [LEN_W-1:0]     req_len,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATA_W-1:0]    in_data,
  input  logic                 in_last,
  output logic                 out_valid,
  output logic [DATA_W+1:0]    out_flit,
  output logic [((VC_NUM > 1) ? $clog2(VC_NUM) : 1)-1:0] out_vc,
  input  logic [VC_NUM-1:0]    credit_in,
  output logic                 err_len
);
  localparam int VC_W   = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;
  localparam int CRED_W = $clog2(VC_DEPTH + 1);
  localparam int HDR_W  = 2*X_W + 2*Y_W + TYPE_W + ORDER_W + LEN_W;

  typedef enum logic {IDLE, BODY} state_t;

  // First member lands in the MSBs, so dst_x ends up at bit 0.
  typedef struct packed {
    logic [LEN_W-1:0]   len;
    logic [ORDER_W-1:0] order;
    logic [TYPE_W-1:0]  typ;
    logic [Y_W-1:0]     src_y;
    logic [X_W-1:0]     src_x;
    logic [Y_W-1:0]     dst_y;
    logic [X_W-1:0]     dst_x;
  } head_t;

  state_t state, state_n;
  logic [VC_NUM-1:0][CRED_W-1:0] cred_cnt;
  logic [VC_NUM-1:0] avail, dec_vec;
  logic [VC_W-1:0]   rr_ptr, vc_q, sel_vc, cand;
  logic              sel_ok;
  int                rr_idx;
  logic [LEN_W-1:0]  len_q, beat_cnt;
  logic              req_acc, beat_acc, is_tail, len_err;
  head_t             hdr;
  logic [DATA_W-1:0] head_pl;

  for (genvar v = 0; v < VC_NUM; v++) begin : g_vc
    noc_pkt_vc_credit #(.DEPTH(VC_DEPTH), .CRED_W(CRED_W)) u_cred (
      .clk(clk), .rst(rst), .inc(credit_in[v]), .dec(dec_vec[v]),
      .cnt(cred_cnt[v]), .avail(avail[v]));
  end

  // Round-robin: first VC with credit, starting just after the last winner.
  always_comb begin
    sel_ok = 1'b0;
    sel_vc = '0;
    rr_idx = 0;
    cand   = '0;
    for (int i = 1; i <= VC_NUM; i++) begin
      rr_idx = int'(rr_ptr) + i;
      if (rr_idx >= VC_NUM) rr_idx = rr_idx - VC_NUM;
      cand = VC_W'(rr_idx);
      if (!sel_ok && avail[cand]) begin
        sel_ok = 1'b1;
        sel_vc = cand;
      end
    end
  end

  assign hdr = '{len: req_len, order: req_order, typ: req_type, src_y: local_y,
                 src_x: local_x, dst_y: req_dest_y, dst_x: req_dest_x};

  always_comb begin
    head_pl = '0;
    head_pl[HDR_W-1:0] = hdr;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n   = state;
    req_ready = 1'b0;
    in_ready  = 1'b0;
    req_acc   = 1'b0;
    beat_acc  = 1'b0;
    is_tail   = 1'b0;
    len_err   = 1'b0;
    case (state)
      IDLE: begin
        req_ready = sel_ok;
        req_acc   = req_valid && sel_ok;
        if (req_acc) state_n = BODY;
      end
      BODY: begin
        in_ready = avail[vc_q];
        beat_acc = in_valid && avail[vc_q];
        if (beat_acc) begin
`ifdef NOC_PKT_LEN_CHECK_EN
          is_tail = (beat_cnt == len_q) || in_last;
          len_err = (beat_cnt == len_q) ^ in_last;
`else
          is_tail = (beat_cnt == len_q);
`endif
          if (is_tail) state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    dec_vec = '0;
    if (req_acc)  dec_vec[sel_vc] = 1'b1;
    if (beat_acc) dec_vec[vc_q]   = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_flit  <= '0;
      out_vc    <= '0;
      rr_ptr    <= VC_W'(VC_NUM - 1);
      vc_q      <= '0;
      len_q     <= '0;
      beat_cnt  <= '0;
    end else begin
      out_valid <= req_acc || beat_acc;
      if (req_acc) begin
        out_flit <= {2'b10, head_pl};
        out_vc   <= sel_vc;
        rr_ptr   <= sel_vc;
        vc_q     <= sel_vc;
        len_q    <= req_len;
        beat_cnt <= '0;
      end else if (beat_acc) begin
        out_flit <= {(is_tail ? 2'b01 : 2'b00), in_data};
        out_vc   <= vc_q;
        beat_cnt <= beat_cnt + 1'b1;
      end
    end
  end

`ifdef NOC_PKT_LEN_CHECK_EN
  always_ff @(posedge clk) begin
    if (rst)          err_len <= 1'b0;
    else if (len_err) err_len <= 1'b1;
  end
`else
  logic unused_in_last;
  assign unused_in_last = in_last ^ len_err;
  assign err_len = 1'b0;
`endif
endmodule

// File: tb/tb_noc_flit_packetizer.sv
// Randomized + directed bench for noc_flit_packetizer against a transaction-level reference model.
module tb_noc_flit_packetizer;
  localparam int NV  = 2;
  localparam int DEP = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  local_x = '0, local_y = '0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [3:0]  req_dest_x = '0, req_dest_y = '0;
  logic [1:0]  req_type = '0;
  logic [3:0]  req_order = '0;
  logic [7:0]  req_len = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] in_data = '0;
  logic        in_last = 1'b0;
  logic        out_valid;
  logic [65:0] out_flit;
  logic [0:0]  out_vc;
  logic [1:0]  credit_in = '0;
  logic        err_len;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model state
  int m_cred[NV];
  int m_rr, m_vc, m_len, m_cnt;
  bit m_pkt, m_err;

  always #5 clk = ~clk;

  noc_flit_packetizer #(.DATA_W(64), .X_W(4), .Y_W(4), .TYPE_W(2), .ORDER_W(4),
                        .LEN_W(8), .VC_NUM(NV), .VC_DEPTH(DEP)) dut (
    .clk(clk), .rst(rst), .local_x(local_x), .local_y(local_y),
    .req_valid(req_valid), .req_ready(req_ready), .req_dest_x(req_dest_x),
    .req_dest_y(req_dest_y), .req_type(req_type), .req_order(req_order),
    .req_len(req_len), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .out_valid(out_valid), .out_flit(out_flit), .out_vc(out_vc),
    .credit_in(credit_in), .err_len(err_len));

  task automatic chk(input string tag, input logic [65:0] got, input logic [65:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic m_init();
    for (int v = 0; v < NV; v++) m_cred[v] = DEP;
    m_rr = NV - 1; m_pkt = 0; m_vc = 0; m_len = 0; m_cnt = 0; m_err = 0;
  endtask

  function automatic logic [63:0] head_payload();
    return 64'(req_dest_x) | (64'(req_dest_y) << 4) | (64'(local_x) << 8) |
           (64'(local_y) << 12) | (64'(req_type) << 16) | (64'(req_order) << 18) |
           (64'(req_len) << 22);
  endfunction

  task automatic idle();
    req_valid = 1'b0; in_valid = 1'b0; in_last = 1'b0; credit_in = '0;
  endtask

  // One clock: check readies, advance model, then check registered outputs.
  task automatic step();
    bit er, eir, eov, hit, tl, found;
    int dec, sel, c;
    logic [65:0] ef;
    logic [0:0] evc;
    #1;
    eov = 0; ef = '0; evc = '0; dec = -1; sel = 0;
    if (rst) begin
      m_init();
    end else begin
      er = 0;
      for (int v = 0; v < NV; v++) if (m_cred[v] > 0) er = 1;
      er  = er && !m_pkt;
      eir = m_pkt && (m_cred[m_vc] > 0);
      chk("req_ready", req_ready, er);
      chk("in_ready", in_ready, eir);
      if (er && req_valid) begin
        found = 0;
        for (int k = 1; k <= NV; k++) begin
          c = (m_rr + k) % NV;
          if (!found && m_cred[c] > 0) begin found = 1; sel = c; end
        end
        ef = {2'b10, head_payload()}; evc = 1'(sel); eov = 1;
        m_rr = sel; m_pkt = 1; m_vc = sel; m_len = int'(req_len); m_cnt = 0; dec = sel;
      end else if (eir && in_valid) begin
        hit = (m_cnt == m_len);
        tl  = hit;
`ifdef NOC_PKT_LEN_CHECK_EN
        tl = hit || in_last;
        if (hit != in_last) m_err = 1;
`endif
        ef = {(tl ? 2'b01 : 2'b00), in_data}; evc = 1'(m_vc); eov = 1;
        dec = m_vc; m_cnt++;
        if (tl) m_pkt = 0;
      end
      for (int v = 0; v < NV; v++) begin
        if (credit_in[v] && dec != v && m_cred[v] < DEP) m_cred[v]++;
        else if (!credit_in[v] && dec == v) m_cred[v]--;
      end
    end
    @(posedge clk); #1;
    chk("out_valid", out_valid, eov);
    if (rst) begin
      chk("rst_flit", out_flit, '0);
      chk("rst_vc", out_vc, '0);
    end else if (eov) begin
      chk("out_flit", out_flit, ef);
      chk("out_vc", out_vc, evc);
    end
    chk("err_len", err_len, m_err);
    for (int v = 0; v < NV; v++) chk("credit", 66'(dut.cred_cnt[v]), 66'(m_cred[v]));
    @(negedge clk);
  endtask

  task automatic do_reset();
    idle(); rst = 1'b1; step(); step(); rst = 1'b0;
  endtask

  task automatic send_req(input int dx, input int dy, input int ln);
    req_dest_x = 4'(dx); req_dest_y = 4'(dy); req_type = '0; req_order = '0;
    req_len = 8'(ln); req_valid = 1'b1; step(); idle();
  endtask

  task automatic send_beat(input bit last);
    in_valid = 1'b1; in_last = last; in_data = {$urandom(), $urandom()}; step(); idle();
  endtask

  initial begin
    @(negedge clk);
    do_reset();
    chk("rst_req_ready", req_ready, 1'b1);
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_flit", out_flit, '0);
    chk("rst_err_len", err_len, 1'b0);

    // single packet dest (2,1) len 2 from (0,0)
    send_req(2, 1, 2);
    chk("t1_head_type", out_flit[65:64], 2'b10);
    chk("t1_head_pl", out_flit[63:0], 64'h800012);
    chk("t1_head_vc", out_vc, 1'b0);
    send_beat(0); chk("t1_b0_type", out_flit[65:64], 2'b00);
    send_beat(0); chk("t1_b1_type", out_flit[65:64], 2'b00);
    send_beat(1); chk("t1_tail_type", out_flit[65:64], 2'b01);

    // four len-0 packets alternate VCs and drain every credit
    do_reset();
    send_req(1, 1, 0); chk("t2_vc_a", out_vc, 1'b0); send_beat(1);
    send_req(1, 2, 0); chk("t2_vc_b", out_vc, 1'b1); send_beat(1);
    send_req(2, 2, 0); chk("t2_vc_c", out_vc, 1'b0); send_beat(1);
    send_req(3, 2, 0); chk("t2_vc_d", out_vc, 1'b1); send_beat(1);
    chk("t3_exhaust_rrdy", req_ready, 1'b0);
    credit_in = 2'b10; step(); idle();
    chk("t3_return_rrdy", req_ready, 1'b1);
    send_req(0, 3, 1); chk("t3_sel_vc1", out_vc, 1'b1);
    in_valid = 1'b1; in_data = {$urandom(), $urandom()};
    chk("t3_stall_irdy", in_ready, 1'b0);
    step(); step();
    credit_in = 2'b10; step();
    chk("t3_post_ret_irdy", in_ready, 1'b1);
    step();
    chk("t4_same_cycle_cred", 66'(dut.cred_cnt[1]), 66'd1);
    credit_in = '0; in_last = 1'b1; step(); idle();
    chk("t3_tail_type", out_flit[65:64], 2'b01);

`ifdef NOC_PKT_LEN_CHECK_EN
    do_reset();
    send_req(1, 0, 3);
    send_beat(0);
    send_beat(1);
    chk("t5_early_tail", out_flit[65:64], 2'b01);
    chk("t5_err_set", err_len, 1'b1);
    step(); step(); step();
    chk("t5_err_sticky", err_len, 1'b1);
    do_reset();
    chk("t5_err_clr", err_len, 1'b0);
`endif

    // reset in the middle of a packet
    do_reset();
    send_req(2, 2, 3);
    send_beat(0);
    rst = 1'b1; step(); rst = 1'b0;
    chk("t6_out_valid", out_valid, 1'b0);
    chk("t6_req_ready", req_ready, 1'b1);
    chk("t6_in_ready", in_ready, 1'b0);

    // randomized traffic
    local_x = 4'd3; local_y = 4'd5;
    for (int n = 0; n < 1500; n++) begin
      rst        = ($urandom_range(0, 199) == 0);
      req_valid  = 1'($urandom_range(0, 1));
      req_dest_x = 4'($urandom()); req_dest_y = 4'($urandom());
      req_type   = 2'($urandom()); req_order  = 4'($urandom());
      req_len    = 8'($urandom_range(0, 4));
      in_valid   = ($urandom_range(0, 9) < 7);
      in_data    = {$urandom(), $urandom()};
`ifdef NOC_PKT_LEN_CHECK_EN
      in_last    = (m_pkt && m_cnt == m_len) ^ ($urandom_range(0, 15) == 0);
`else
      in_last    = 1'($urandom_range(0, 1));
`endif
      credit_in  = {($urandom_range(0, 9) < 3), ($urandom_range(0, 9) < 3)};
      step();
    end
    rst = 1'b0; idle(); step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
